// File: rtl/potential_reader.sv
// Purpose: snapshot a bank of stored membrane potentials, then stream it out in index order while counting the entries at or above the firing threshold.
// Latency: out_valid rises one cycle after the start edge; N_NEURONS beats plus one done cycle when out_ready stays high.
// Backpressure: out_ready low stalls the stream and holds every out_* output stable. out_valid never depends on out_ready.
module potential_reader #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 2,
    parameter int THRESHOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_NEURONS*WIDTH-1:0] in_flat,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [IDX_W:0]             spike_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic signed [WIDTH-1:0] THR      = WIDTH'(THRESHOLD);

    state_t                   state;
    logic signed [WIDTH-1:0]  snap [N_NEURONS];
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         nxt_idx;
    logic [IDX_W:0]           spike_cnt;

    assign nxt_idx = idx + IDX_W'(1);

    // The count is taken from the frozen snapshot, so in_flat can change during the stream without affecting it.
    always_comb begin
        spike_cnt = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (snap[k] >= THR)
                spike_cnt = spike_cnt + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_count <= '0;
            for (int k = 0; k < N_NEURONS; k++)
                snap[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < N_NEURONS; k++)
                            snap[k] <= in_flat[k*WIDTH +: WIDTH];
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= in_flat[WIDTH-1:0];
                        out_idx   <= '0;
                        out_last  <= (LAST_IDX == '0);
                        busy      <= 1'b1;
                        state     <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid   <= 1'b0;
                            out_data    <= '0;
                            out_idx     <= '0;
                            out_last    <= 1'b0;
                            done        <= 1'b1;
                            spike_count <= spike_cnt;
                            state       <= ST_DONE;
                        end else begin
                            idx      <= nxt_idx;
                            out_idx  <= nxt_idx;
                            out_data <= snap[nxt_idx];
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
